pad_cfg_sequencer: RTL and testbench

Power-up configuration sequencer for the user-area GPIO pad ring. It snapshots a flat per-pad configuration vector and resets the serial configuration chain that runs through the pad control blocks. It then shifts the vector into the chain at a divided serial rate and pulses a load strobe so every pad latches its new mode. It sits beside the pad-ring wrapper and generalises single-pad static hookup to NUM_PADS pads of CFG_BITS bits each.

---
 rtl/pad_cfg_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pad_cfg_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pad_cfg_sequencer.sv
// Power-up pad configuration sequencer: snapshots cfg_data, resets the pad chain, shifts the
// snapshot in MSB first at a divided rate and pulses serial_load. Optional macro PAD_CFG_READBACK_EN.
module pad_cfg_sequencer #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_PADS*CFG_BITS-1:0]   cfg_data,
    output logic                           busy,
    output logic                           done,
    output logic                           serial_resetn,
    output logic                           serial_clock,
    output logic                           serial_data_out,
    output logic                           serial_load,
    input  logic                           serial_data_in,
    output logic                           cfg_err
);
    localparam int N     = NUM_PADS * CFG_BITS;
    localparam int P     = 2 * CLK_DIV;
    localparam int PH_W  = $clog2(P);
    localparam int BIT_W = $clog2(N + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(P - 1);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]  PH_PRE   = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHAIN_RST, S_SHIFT, S_VERIFY, S_LOAD, S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [N-1:0]       snap_q, snap_d;
    logic [N-1:0]       snap_sel;
    logic               err_q, err_d;
    logic               ph_wrap;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               resetn_q, resetn_d;
    logic               sclk_q, sclk_d;
    logic               data_out_q, data_out_d;
    logic               load_q, load_d;
    logic               shifting_d;

`ifndef PAD_CFG_READBACK_EN
    logic unused_sdi;
    assign unused_sdi = serial_data_in;
`endif

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        snap_d  = snap_q;
        err_d   = err_q;
        ph_wrap = (ph_q == PH_LAST);

        if (state_q != S_IDLE && state_q != S_FIN) begin
            ph_d = ph_wrap ? '0 : ph_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = cfg_data;
                    err_d   = 1'b0;
                    bit_d   = '0;
                    ph_d    = '0;
                    state_d = S_CHAIN_RST;
                end
            end
            S_CHAIN_RST: begin
                if (ph_wrap) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (ph_wrap) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef PAD_CFG_READBACK_EN
                        state_d = S_VERIFY;
`else
                        state_d = S_LOAD;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef PAD_CFG_READBACK_EN
            S_VERIFY: begin
                // Sample on the edge that raises serial_clock, before the chain shifts.
                if (ph_q == PH_PRE && serial_data_in != data_out_q) err_d = 1'b1;
                if (ph_wrap) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`endif
            S_LOAD: begin
                if (ph_wrap) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the chain sees glitch-free levels.
        shifting_d = (state_d == S_SHIFT) || (state_d == S_VERIFY);
        busy_d     = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d     = (state_d == S_FIN);
        resetn_d   = (state_d != S_CHAIN_RST);
        sclk_d     = shifting_d && (ph_d >= PH_RISE);
        load_d     = (state_d == S_LOAD) && (ph_d < PH_RISE);
        snap_sel   = snap_d >> (BIT_LAST - bit_d);
        data_out_d = shifting_d ? snap_sel[0] : data_out_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            bit_q      <= '0;
            snap_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            resetn_q   <= 1'b1;
            sclk_q     <= 1'b0;
            data_out_q <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            snap_q     <= snap_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            resetn_q   <= resetn_d;
            sclk_q     <= sclk_d;
            data_out_q <= data_out_d;
            load_q     <= load_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign serial_resetn   = resetn_q;
    assign serial_clock    = sclk_q;
    assign serial_data_out = data_out_q;
    assign serial_load     = load_q;
    assign cfg_err         = err_q;

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed bench for pad_cfg_sequencer: a CLK_DIV=1 and a CLK_DIV=3 instance, shift-register
// chain models on serial_clock, and a queue of expected serial bits popped on each rising edge.
module tb_pad_cfg_sequencer;
    localparam int NP = 2;
    localparam int CB = 4;
    localparam int N  = NP * CB;
`ifdef PAD_CFG_READBACK_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_start = 1'b0, b_start = 1'b0;
    logic [N-1:0] a_cfg = '0, b_cfg = '0;
    logic busy_a, done_a, rn_a, sclk_a, sdo_a, load_a, sdi_a, err_a;
    logic busy_b, done_b, rn_b, sclk_b, sdo_b, load_b, sdi_b, err_b;
    logic [7:0]   chain_a = '0, chain_b = '0;
    logic [2:0]   chain_top = 3'd7;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         sb[$];

    always #5 clk = ~clk;

    always @(posedge sclk_a) chain_a <= {chain_a[6:0], sdo_a};
    always @(posedge sclk_b) chain_b <= {chain_b[6:0], sdo_b};
    assign sdi_a = chain_a[chain_top];
    assign sdi_b = chain_b[7];

    pad_cfg_sequencer #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(1)) dut_a (
        .clock(clk), .reset(rst), .start(a_start), .cfg_data(a_cfg),
        .busy(busy_a), .done(done_a), .serial_resetn(rn_a), .serial_clock(sclk_a),
        .serial_data_out(sdo_a), .serial_load(load_a), .serial_data_in(sdi_a), .cfg_err(err_a)
    );

    pad_cfg_sequencer #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(3)) dut_b (
        .clock(clk), .reset(rst), .start(b_start), .cfg_data(b_cfg),
        .busy(busy_b), .done(done_b), .serial_resetn(rn_b), .serial_clock(sclk_b),
        .serial_data_out(sdo_b), .serial_load(load_b), .serial_data_in(sdi_b), .cfg_err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_resetn"}, rn_a, 1);
        check({tag, "_sclk"}, sclk_a, 0);
        check({tag, "_sdo"}, sdo_a, 0);
        check({tag, "_load"}, load_a, 0);
        check({tag, "_err"}, err_a, 0);
    endtask

    // Queue the expected stream, raise start, and stop on the first busy cycle.
    task automatic launch(input bit use_b, input logic [7:0] data);
        for (int r = 0; r < PASSES; r++)
            for (int i = 7; i >= 0; i--) sb.push_back(data[i]);
        if (use_b) begin b_cfg = data; b_start = 1'b1; end
        else       begin a_cfg = data; a_start = 1'b1; end
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        check(use_b ? "b_busy_rise" : "a_busy_rise", use_b ? busy_b : busy_a, 1);
        check(use_b ? "b_err_clear" : "a_err_clear", use_b ? err_b : err_a, 0);
    endtask

    // mode 0: plain run; mode 1: start/cfg_data poked mid-shift; mode 2: reset in slot 4.
    task automatic observe(input bit use_b, input int mode, input int exp_lat, input logic exp_err);
        int   cdiv = use_b ? 3 : 1;
        int   cyc = 0, rn_low = 0, load_hi = 0, rises = 0, done_at = -1;
        int   hi_run = 0, lo_run = 0, stable = 0;
        logic sclk, sdo, prev_sclk, prev_sdo, exp_bit;
        string pfx = use_b ? "b" : "a";
        prev_sclk = 1'b0;
        prev_sdo  = use_b ? sdo_b : sdo_a;
        while (cyc < 400 && done_at < 0) begin
            sclk = use_b ? sclk_b : sclk_a;
            sdo  = use_b ? sdo_b : sdo_a;
            if (!(use_b ? rn_b : rn_a)) rn_low++;
            if (use_b ? load_b : load_a) load_hi++;
            if (sdo !== prev_sdo) stable = 0;
            if (sclk && !prev_sclk) begin
                if (rises > 0) check($sformatf("%s_low_run%0d", pfx, rises), lo_run, cdiv);
                check($sformatf("%s_setup%0d", pfx, rises), stable >= cdiv, 1);
                if (sb.size() == 0) check($sformatf("%s_extra_rise", pfx), rises, 8 * PASSES);
                else begin
                    exp_bit = sb.pop_front();
                    check($sformatf("%s_bit%0d", pfx, rises), sdo, exp_bit);
                end
                rises++;
                hi_run = 0;
            end
            if (!sclk && prev_sclk) begin
                check($sformatf("%s_high_run%0d", pfx, rises), hi_run, cdiv);
                lo_run = 0;
            end
            if (sclk) hi_run++; else lo_run++;
            stable++;
            if (use_b ? done_b : done_a) begin
                done_at = cyc;
                check({pfx, "_busy_at_done"}, use_b ? busy_b : busy_a, 0);
            end
            if (mode == 1 && cyc == 6) begin
                a_cfg   = '0;
                a_start = 1'b1;
            end
            if (mode == 2 && cyc == 10) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_outs("midrst");
                check("midrst_no_load", load_hi, 0);
                sb.delete();
                return;
            end
            prev_sclk = sclk;
            prev_sdo  = sdo;
            if (done_at < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check({pfx, "_done_latency"}, done_at, exp_lat);
        check({pfx, "_resetn_low"}, rn_low, 2 * cdiv);
        check({pfx, "_load_high"}, load_hi, cdiv);
        check({pfx, "_rises"}, rises, 8 * PASSES);
        check({pfx, "_sb_empty"}, sb.size(), 0);
        check({pfx, "_cfg_err"}, use_b ? err_b : err_a, exp_err);
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outs("reset");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle_busy%0d", i), busy_a, 0);
        end

        // Basic load
        launch(0, 8'hA5);
        observe(0, 0, 2 * (PASSES * 8 + 2), 0);
        @(negedge clk);

        // Divider timing
        launch(1, 8'h81);
        observe(1, 0, 6 * (PASSES * 8 + 2), 0);
        @(negedge clk);

        // Start while busy, then held through the done cycle
        launch(0, 8'hA5);
        observe(0, 1, 2 * (PASSES * 8 + 2), 0);
        @(negedge clk);
        check("fin_start_not_taken", busy_a, 0);
        for (int r = 0; r < PASSES; r++)
            for (int i = 0; i < 8; i++) sb.push_back(1'b0);
        @(negedge clk);
        check("restart_busy", busy_a, 1);
        check("restart_resetn", rn_a, 0);
        a_start = 1'b0;
        observe(0, 0, 2 * (PASSES * 8 + 2), 0);
        @(negedge clk);

        // Mid-run reset, then a full sequence
        launch(0, 8'h3C);
        observe(0, 2, 0, 0);
        @(negedge clk);
        launch(0, 8'h3C);
        observe(0, 0, 2 * (PASSES * 8 + 2), 0);
        @(negedge clk);

        // Short chain: readback mismatch when enabled, then cleared by the next start
        chain_top = 3'd6;
        launch(0, 8'hA5);
        observe(0, 0, 2 * (PASSES * 8 + 2), (PASSES == 2) ? 1'b1 : 1'b0);
        @(negedge clk);
        chain_top = 3'd7;
        launch(0, 8'h5A);
        observe(0, 0, 2 * (PASSES * 8 + 2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
